// File: rtl/cnt_ramp_ctrl_if.sv
// Counter control bus between the ramp sequencer and the PWM counter.
// master = sequencer (drives), slave = counter (receives).
interface cnt_ramp_ctrl_if #(
   parameter int W = 16
);
   logic         en;
   logic         clr;
   logic         ld;
   logic [W-1:0] ld_val;
   logic [W-1:0] thr;

   modport master (
      output en, clr, ld, ld_val, thr
   );

   modport slave (
      input en, clr, ld, ld_val, thr
   );
endinterface

// File: rtl/cnt_ramp_ctrl.sv
// Duty-cycle ramp sequencer driving the PWM counter control bus.
// Optional sticky completion IRQ: define CNT_RAMP_IRQ_EN.
module cnt_ramp_ctrl #(
   parameter  int W      = 16,
   parameter  int NSTEPS = 8,
   parameter  int RW     = 8,
   localparam int IW     = $clog2(NSTEPS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          loop_i,
   input  logic [W-1:0]  period_i,
   input  logic [IW:0]   nsteps_i,
   input  logic          cfg_we_i,
   input  logic [IW-1:0] cfg_idx_i,
   input  logic [6:0]    cfg_duty_i,
   input  logic [RW-1:0] cfg_reps_i,
   cnt_ramp_ctrl_if.master cnt,
   output logic          busy_o,
   output logic [IW-1:0] step_o,
   output logic          done_o
`ifdef CNT_RAMP_IRQ_EN
   ,
   output logic          irq_o,
   input  logic          irq_clr_i
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LOAD,
      SETTLE,
      RUN
   } state_t;

   localparam logic [IW:0] N_ONE = (IW+1)'(1);
   localparam logic [IW:0] N_MAX = (IW+1)'(NSTEPS);

   state_t        state_q;
   logic          abort_q;
   logic [6:0]    duty_q [NSTEPS];
   logic [RW-1:0] reps_q [NSTEPS];
   logic [W-1:0]  period_q;
   logic [IW:0]   nsteps_q;
   logic [W-1:0]  cyc_q;
   logic [RW-1:0] rep_q;
   logic [RW-1:0] cur_reps_q;

   logic start_ok;
   logic period_end;
   logic rep_end;
   logic last_step;

   assign start_ok   = start_i && !stop_i
                    && (period_i != '0)
                    && (nsteps_i != '0)
                    && (nsteps_i <= N_MAX);
   assign period_end = (cyc_q == period_q - W'(1));
   assign rep_end    = (rep_q == cur_reps_q - RW'(1));
   assign last_step  = (({1'b0, step_o} + N_ONE) == nsteps_q);

   // Step table; duty clamped to 100 %, zero repeats stored as one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NSTEPS; i++) begin
            duty_q[i] <= '0;
            reps_q[i] <= RW'(1);
         end
      end else if (cfg_we_i) begin
         duty_q[cfg_idx_i] <= (cfg_duty_i > 7'd100)
                            ? 7'd100 : cfg_duty_i;
         reps_q[cfg_idx_i] <= (cfg_reps_i == '0)
                            ? RW'(1) : cfg_reps_i;
      end
   end

   // Sequencer FSM; every output is registered with its state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         abort_q    <= 1'b0;
         period_q   <= '0;
         nsteps_q   <= '0;
         cyc_q      <= '0;
         rep_q      <= '0;
         cur_reps_q <= '0;
         cnt.en     <= 1'b0;
         cnt.clr    <= 1'b0;
         cnt.ld     <= 1'b0;
         cnt.ld_val <= '0;
         cnt.thr    <= '0;
         busy_o     <= 1'b0;
         step_o     <= '0;
         done_o     <= 1'b0;
      end else begin
         cnt.clr <= 1'b0;
         cnt.ld  <= 1'b0;
         done_o  <= 1'b0;
         if (state_q != IDLE && stop_i) begin
            cnt.en <= 1'b0;
            if (state_q == CLR && abort_q) begin
               state_q <= IDLE;
               abort_q <= 1'b0;
               busy_o  <= 1'b0;
            end else begin
               state_q <= CLR;
               abort_q <= 1'b1;
               cnt.clr <= 1'b1;
            end
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (start_ok) begin
                     period_q <= period_i;
                     nsteps_q <= nsteps_i;
                     step_o   <= '0;
                     abort_q  <= 1'b0;
                     state_q  <= CLR;
                     cnt.clr  <= 1'b1;
                     busy_o   <= 1'b1;
                  end
               end
               CLR: begin
                  if (abort_q) begin
                     state_q <= IDLE;
                     abort_q <= 1'b0;
                     busy_o  <= 1'b0;
                  end else begin
                     state_q    <= LOAD;
                     cnt.ld     <= 1'b1;
                     cnt.ld_val <= W'(duty_q[step_o]);
                     cnt.thr    <= period_q;
                     cur_reps_q <= reps_q[step_o];
                  end
               end
               LOAD: begin
                  state_q <= SETTLE;
               end
               SETTLE: begin
                  state_q <= RUN;
                  cnt.en  <= 1'b1;
                  cyc_q   <= '0;
                  rep_q   <= '0;
               end
               RUN: begin
                  if (!period_end) begin
                     cyc_q <= cyc_q + W'(1);
                  end else begin
                     cyc_q <= '0;
                     if (!rep_end) begin
                        rep_q <= rep_q + RW'(1);
                     end else begin
                        cnt.en <= 1'b0;
                        if (!last_step) begin
                           step_o  <= step_o + IW'(1);
                           state_q <= CLR;
                           cnt.clr <= 1'b1;
                        end else if (loop_i) begin
                           step_o  <= '0;
                           state_q <= CLR;
                           cnt.clr <= 1'b1;
                        end else begin
                           state_q <= IDLE;
                           busy_o  <= 1'b0;
                           done_o  <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
                  cnt.en  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef CNT_RAMP_IRQ_EN
   // Sticky completion flag; a clear in the same cycle wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_o <= 1'b0;
      end else if (irq_clr_i) begin
         irq_o <= 1'b0;
      end else if (done_o) begin
         irq_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cnt_ramp_ctrl.sv
// Directed bench for cnt_ramp_ctrl: vector table plus
// hand-written multi-cycle sequences.
module tb_cnt_ramp_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [15:0] period = '0;
   logic [3:0]  nsteps = '0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_idx = '0;
   logic [6:0]  cfg_duty = '0;
   logic [7:0]  cfg_reps = '0;
   logic        busy;
   logic [2:0]  step;
   logic        done;
`ifdef CNT_RAMP_IRQ_EN
   logic        irq;
   logic        irq_clr = 1'b0;
`endif

   cnt_ramp_ctrl_if #(.W(16)) cif ();

   cnt_ramp_ctrl #(.W(16), .NSTEPS(8), .RW(8)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .stop_i     (stop),
      .loop_i     (loop_en),
      .period_i   (period),
      .nsteps_i   (nsteps),
      .cfg_we_i   (cfg_we),
      .cfg_idx_i  (cfg_idx),
      .cfg_duty_i (cfg_duty),
      .cfg_reps_i (cfg_reps),
      .cnt        (cif),
      .busy_o     (busy),
      .step_o     (step),
      .done_o     (done)
`ifdef CNT_RAMP_IRQ_EN
      ,
      .irq_o      (irq),
      .irq_clr_i  (irq_clr)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   int n_busy, n_en, n_clr, n_ld, n_done, n_both;
   int thr_seen, ended;
   int ldv[$];
   int lds[$];

   typedef struct {
      logic [6:0]  duty;
      logic [7:0]  reps;
      logic [15:0] per;
      int          exp_ld;
      int          exp_en;
      int          exp_busy;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act,
                        input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   task automatic cfg_write(input int idx, input int duty,
                            input int reps);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_idx  = 3'(idx);
      cfg_duty = 7'(duty);
      cfg_reps = 8'(reps);
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   // Start a sequence and count activity until busy drops.
   task automatic run_one(input int per, input int ns,
                          input logic lp, input int poke);
      n_busy = 0; n_en = 0; n_clr = 0; n_ld = 0;
      n_done = 0; n_both = 0; thr_seen = -1; ended = 0;
      ldv.delete();
      lds.delete();
      @(negedge clk);
      period  = 16'(per);
      nsteps  = 4'(ns);
      loop_en = lp;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4000; c++) begin
         if (cif.ld) begin
            ldv.push_back(int'(cif.ld_val));
            lds.push_back(int'(step));
            thr_seen = int'(cif.thr);
            n_ld++;
         end
         if (cif.clr) n_clr++;
         if (cif.en) n_en++;
         if (cif.clr && cif.ld) n_both++;
         if (done) n_done++;
         if (!busy) begin
            ended = 1;
            break;
         end
         n_busy++;
         if (c == poke) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      check("run_finished", ended, 1);
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      int exp_r[4];
      vecs[0] = '{7'd50,  8'd2, 16'd10, 50,  20, 23};
      vecs[1] = '{7'd120, 8'd1, 16'd3,  100, 3,  6};
      vecs[2] = '{7'd0,   8'd0, 16'd5,  0,   5,  8};
      vecs[3] = '{7'd100, 8'd3, 16'd1,  100, 3,  6};
      vecs[4] = '{7'd7,   8'd4, 16'd2,  7,   8,  11};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs",
            int'({cif.en, cif.clr, cif.ld, cif.ld_val,
                  cif.thr, busy, step, done}), 0);
      rst = 1'b0;

      // reset table: duty 0, reps 1
      run_one(2, 1, 1'b0, 0);
      check("rst_tbl_ld", q_at(ldv, 0), 0);
      check("rst_tbl_en", n_en, 2);
      check("rst_tbl_busy", n_busy, 5);

      // table-driven single steps
      for (int v = 0; v < 5; v++) begin
         cfg_write(0, int'(vecs[v].duty), int'(vecs[v].reps));
         run_one(int'(vecs[v].per), 1, 1'b0, 0);
         check($sformatf("v%0d_ldval", v), q_at(ldv, 0),
               vecs[v].exp_ld);
         check($sformatf("v%0d_thr", v), thr_seen,
               int'(vecs[v].per));
         check($sformatf("v%0d_en", v), n_en, vecs[v].exp_en);
         check($sformatf("v%0d_busy", v), n_busy,
               vecs[v].exp_busy);
         check($sformatf("v%0d_done", v), n_done, 1);
         check($sformatf("v%0d_clr", v), n_clr, 1);
         check($sformatf("v%0d_ld", v), n_ld, 1);
         check($sformatf("v%0d_both", v), n_both, 0);
      end

      // four-step ramp
      exp_r[0] = 0; exp_r[1] = 25; exp_r[2] = 75; exp_r[3] = 100;
      for (int i = 0; i < 4; i++) cfg_write(i, exp_r[i], 1);
      run_one(4, 4, 1'b0, 0);
      check("ramp_busy", n_busy, 28);
      check("ramp_en", n_en, 16);
      check("ramp_done", n_done, 1);
      check("ramp_clr", n_clr, 4);
      check("ramp_nld", n_ld, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ramp_ld%0d", i), q_at(ldv, i), exp_r[i]);
         check($sformatf("ramp_step%0d", i), q_at(lds, i), i);
      end

      // loop wrap then stop in RUN
      cfg_write(0, 10, 1);
      cfg_write(1, 20, 1);
      n_ld = 0; n_done = 0;
      lds.delete();
      ldv.delete();
      @(negedge clk);
      period = 16'd3; nsteps = 4'd2; loop_en = 1'b1; start = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (cif.ld) begin
            n_ld++;
            lds.push_back(int'(step));
            ldv.push_back(int'(cif.ld_val));
         end
         if (done) n_done++;
      end
      check("loop_nld", n_ld, 3);
      check("loop_step1", q_at(lds, 1), 1);
      check("loop_wrap", q_at(lds, 2), 0);
      check("loop_wrap_ld", q_at(ldv, 2), 10);
      check("loop_nodone", n_done, 0);
      check("loop_run", int'({busy, cif.en, step}), 'b1_1_000);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_clr", int'({busy, cif.clr, cif.en, done}),
            'b1_1_0_0);
      @(negedge clk);
      check("stop_idle", int'({busy, cif.clr, cif.en, done}), 0);
      n_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      check("stop_quiet", n_done, 0);
      loop_en = 1'b0;

      // start while busy is ignored
      cfg_write(0, 33, 1);
      run_one(4, 1, 1'b0, 3);
      check("busy_start_busy", n_busy, 7);
      check("busy_start_ld", n_ld, 1);
      check("busy_start_done", n_done, 1);

      // illegal starts and start+stop in IDLE
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         period = (k == 0) ? 16'd0 : 16'd4;
         nsteps = (k == 1) ? 4'd0 : ((k == 2) ? 4'd9 : 4'd1);
         stop   = (k == 3);
         start  = 1'b1;
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
         n_busy = 0;
         repeat (3) begin
            if (busy || cif.clr || cif.ld) n_busy++;
            @(negedge clk);
         end
         check($sformatf("illegal%0d", k), n_busy, 0);
      end

      // reset mid-sequence
      @(negedge clk);
      period = 16'd10; nsteps = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_outs",
            int'({cif.en, cif.clr, cif.ld, cif.ld_val,
                  cif.thr, busy, step, done}), 0);
      rst = 1'b0;
      run_one(2, 1, 1'b0, 0);
      check("mid_rst_tbl", q_at(ldv, 0), 0);

`ifdef CNT_RAMP_IRQ_EN
      run_one(2, 1, 1'b0, 0);
      @(negedge clk);
      check("irq_set", int'(irq), 1);
      @(negedge clk);
      check("irq_hold", int'(irq), 1);
      irq_clr = 1'b1;
      @(negedge clk);
      check("irq_clr", int'(irq), 0);
      run_one(2, 1, 1'b0, 0);
      check("irq_both_done", n_done, 1);
      @(negedge clk);
      irq_clr = 1'b0;
      check("irq_clr_wins", int'(irq), 0);
      @(negedge clk);
      check("irq_stays0", int'(irq), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cnt_ramp_ctrl.md
Name: cnt_ramp_ctrl

Overview:
Sequencer that drives the PWM counter (en/clr/ld/ld_val/thr interface) through a programmable table of duty-cycle steps, producing fades and ramps without software intervention. Each step holds one duty value (0-100 %) for a programmable number of PWM periods, then the next step is loaded. Sits between the register interface and the PWM counter instance; it owns every control input of the counter.

Parameters:
W, 16, counter/period width; must match the driven PWM counter.
NSTEPS, 8, duty table depth (power of 2, >=2); IW = $clog2(NSTEPS).
RW, 8, width of per-step repeat count.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  pulse; start sequence at step 0
stop_i  in  1  pulse; abort sequence
loop_i  in  1  1: wrap to step 0 after last step; 0: finish
period_i  in  W  PWM period in cycles; sampled on accepted start
nsteps_i  in  IW+1  active steps (1..NSTEPS); sampled on accepted start
cfg_we_i  in  1  table write strobe
cfg_idx_i  in  IW  table entry
cfg_duty_i  in  7  duty %, values >100 stored as 100
cfg_reps_i  in  RW  periods per step, 0 stored as 1
cnt_en_o  out  1  to counter en_i
cnt_clr_o  out  1  to counter clr_i
cnt_ld_o  out  1  to counter ld_i
cnt_ld_val_o  out  W  to counter ld_val_i (duty, zero-extended)
cnt_thr_o  out  W  to counter thr_i (latched period)
busy_o  out  1  sequence active (state != IDLE)
step_o  out  IW  current step index
done_o  out  1  one-cycle pulse at normal completion

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i synchronous, active-high. Reset: state IDLE; all outputs 0; table entries duty=0, reps=1; period/nsteps registers 0.
- Table write: any state, one cycle; if written index is the step in RUN, new values take effect only on that step's next load.
- States: IDLE, CLR, LOAD, SETTLE, RUN.
- IDLE: start_i accepted only if period_i!=0 and 1<=nsteps_i<=NSTEPS; else ignored (stay IDLE, no pulse). Accept: latch period/nsteps, step=0, go CLR.
- CLR (1 cycle): cnt_clr_o=1, cnt_en_o=0 -> LOAD.
- LOAD (1 cycle): cnt_ld_o=1, cnt_ld_val_o=table[step].duty, cnt_thr_o=period -> SETTLE.
- SETTLE (1 cycle): all strobes 0, cnt_en_o=0 (counter's internal update cycle) -> RUN; cyc=0, rep=0.
- RUN: cnt_en_o=1. cyc increments each cycle; at cyc==period-1: cyc=0, period complete. On period complete with rep==reps-1: step end; else rep++.
- Step end: if step<nsteps-1: step++, go CLR. If last step and loop_i=1 (sampled at step end): step=0, go CLR. Else: done_o=1 for that cycle, go IDLE, cnt_en_o=0.
- Step occupancy: exactly 3 + reps*period cycles (CLR+LOAD+SETTLE+RUN).
- stop_i: any non-IDLE state -> next cycle cnt_clr_o=1 for one cycle, then IDLE; no done_o. Stop in IDLE: no effect. stop_i and start_i same cycle: stop wins.
- start_i while busy: ignored.
- cnt_ld_val_o/cnt_thr_o hold last loaded values outside LOAD; strobes cnt_clr_o/cnt_ld_o are single-cycle, never simultaneous.
- rst_i mid-sequence: immediate return to reset values next edge.
- Arithmetic: cyc is W bits, rep is RW bits, no wrap possible given compare limits.

Optional Feature:
Macro CNT_RAMP_IRQ_EN. Defined: adds ports irq_o (out,1) and irq_clr_i (in,1); irq_o set on done_o, sticky until irq_clr_i (clear wins if same cycle); reset 0. Not defined: ports absent, done_o only completion indication.

Test Plan:
- Reset: rst_i=1 2 cycles -> all outputs 0, busy_o=0; table reads duty 0/reps 1 via start with nsteps=1 -> ld_val 0.
- Single step: table[0]={50,2}, period=10, nsteps=1, loop=0, start -> clr at t+1, ld with ld_val=50 thr=10 at t+2, en high 20 cycles, done_o pulse, busy_o falls; total 23 cycles.
- Ramp: 4 steps duty {0,25,75,100}, reps 1, period 4 -> step_o 0..3, each ld_val in order, 7 cycles per step, one done_o.
- Loop + stop: 2 steps, loop=1 -> step_o wraps 1->0 with no done_o; assert stop_i in RUN -> one clr cycle, IDLE, en 0, no done_o.
- Illegal/edge: start with period=0 or nsteps=0 -> ignored; cfg_duty=120 -> ld_val 100; cfg_reps=0 -> 1 period; start while busy ignored; start+stop same cycle in IDLE -> stay IDLE.
- IRQ (CNT_RAMP_IRQ_EN): completion -> irq_o=1 held until irq_clr_i; clr and done same cycle -> irq_o=0.
